mem_port_arb: RTL and testbench

- Two-requester round-robin arbiter sharing the single SDRAM controller command port (address / w_rn / go / valid, 64-bit data) between the DSEC input-fetch path (requester 0) and the DSEC output-writeback path (requester 1).
- Latches one command per grant, drives the controller go/valid handshake, and returns read data plus a completion ack to the winning requester.
- A watchdog aborts transactions whose valid never arrives.

---
 rtl/mem_port_arb.sv | 139 +++++++++++++
 tb/tb_mem_port_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Two-requester round-robin arbiter in front of the single SDRAM controller command port.
// One command is latched per grant, issued with go held until valid, or aborted by a watchdog.
module mem_port_arb #(
  parameter int AW      = 13,
  parameter int DW      = 64,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          w_rn0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          w_rn1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          tout,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_w_rn,
  output logic          mem_go,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state, state_d;
  logic          last_grant, last_grant_d;
  logic [CW-1:0] watchdog, watchdog_d;
  logic          pick;
  logic          ack0_d, ack1_d, tout_d, mem_go_d, mem_w_rn_d, gnt_id_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, rdata_d;

  // Under contention the requester that was not served last wins.
  assign pick = (req0 && req1) ? ~last_grant : req1;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    watchdog_d   = watchdog;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    tout_d       = 1'b0;
    mem_go_d     = mem_go;
    mem_w_rn_d   = mem_w_rn;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    gnt_id_d     = gnt_id;
    rdata_d      = rdata;

    case (state)
      IDLE: begin
        mem_go_d = 1'b0;
        if (req0 || req1) begin
          mem_addr_d   = pick ? addr1  : addr0;
          mem_w_rn_d   = pick ? w_rn1  : w_rn0;
          mem_wdata_d  = pick ? wdata1 : wdata0;
          mem_go_d     = 1'b1;
          gnt_id_d     = pick;
          last_grant_d = pick;
          watchdog_d   = '0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_valid) begin
          rdata_d  = mem_rdata;
          mem_go_d = 1'b0;
          ack0_d   = ~gnt_id;
          ack1_d   = gnt_id;
          state_d  = DONE;
        end else if (watchdog == CW'(TIMEOUT - 1)) begin
          // Abort: complete the handshake towards the requester, keep old rdata.
          mem_go_d = 1'b0;
          ack0_d   = ~gnt_id;
          ack1_d   = gnt_id;
          tout_d   = 1'b1;
          state_d  = DONE;
        end else begin
          watchdog_d = watchdog + CW'(1);
        end
      end

      DONE: begin
        mem_go_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        mem_go_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      watchdog   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      tout       <= 1'b0;
      mem_go     <= 1'b0;
      mem_w_rn   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      gnt_id     <= 1'b0;
      rdata      <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      watchdog   <= watchdog_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      tout       <= tout_d;
      mem_go     <= mem_go_d;
      mem_w_rn   <= mem_w_rn_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      gnt_id     <= gnt_id_d;
      rdata      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a small controller responder; TIMEOUT is shortened to 8.
module tb_mem_port_arb;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, w_rn0, req1, w_rn1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, tout, mem_w_rn, mem_go, gnt_id, mem_valid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  mem_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(8), .CW(13)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .w_rn0(w_rn0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .w_rn1(w_rn1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .tout(tout), .rdata(rdata),
    .mem_addr(mem_addr), .mem_w_rn(mem_w_rn), .mem_go(mem_go), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller model: counts go-high cycles, pulses valid on the delay-th one
  // (delay 0 = never), and returns what the requester sees on the ack cycle.
  task automatic serve(input int delay, input logic [63:0] rd, output int go_cnt,
                       output logic a0, output logic a1, output logic to,
                       output logic g, output logic [63:0] rdo);
    bit seen = 0;
    int n = 0;
    go_cnt = 0; a0 = 0; a1 = 0; to = 0; g = 0; rdo = '0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      mem_valid = 1'b0;
      if (ack0 || ack1) begin
        seen = 1; a0 = ack0; a1 = ack1; to = tout; g = gnt_id; rdo = rdata;
      end else if (mem_go) begin
        go_cnt++;
        if (go_cnt == delay) begin
          mem_valid = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    check("ack_seen", 64'(seen), 64'd1);
  endtask

  int          gc;
  logic        a0, a1, to, g;
  logic [63:0] rdo;

  initial begin
    rst = 1'b0;
    req0 = 0; req1 = 0; w_rn0 = 0; w_rn1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_valid = 0; mem_rdata = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_go", 64'(mem_go), 0);
    check("rst_acks", 64'({ack0, ack1, tout}), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_gnt", 64'(gnt_id), 0);
    rst = 1'b1;

    // Contention from reset: grant order 0,1,0,1
    req0 = 1; req1 = 1; addr0 = 13'h010; addr1 = 13'h020;
    for (int k = 0; k < 4; k++) begin
      serve(2, 64'h100 + 64'(k), gc, a0, a1, to, g, rdo);
      check($sformatf("cont%0d_ack0", k), 64'(a0), 64'((k % 2) == 0));
      check($sformatf("cont%0d_ack1", k), 64'(a1), 64'((k % 2) == 1));
      check($sformatf("cont%0d_gnt", k), 64'(g), 64'(k % 2));
      check($sformatf("cont%0d_rdata", k), rdo, 64'h100 + 64'(k));
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end else begin
        if (a0) req0 = 0;
        else req1 = 0;
        @(negedge clk);
        req0 = 1; req1 = 1;
      end
    end

    // Single read, valid after 5 ISSUE cycles
    @(negedge clk);
    req0 = 1; w_rn0 = 0; addr0 = 13'h0A5;
    serve(5, 64'hDEAD_BEEF_0123_4567, gc, a0, a1, to, g, rdo);
    req0 = 0;
    check("rd_go_cycles", 64'(gc), 5);
    check("rd_acks", 64'({a0, a1, to}), 64'b100);
    check("rd_rdata", rdo, 64'hDEAD_BEEF_0123_4567);
    check("rd_addr", 64'(mem_addr), 64'h0A5);
    check("rd_w_rn", 64'(mem_w_rn), 0);
    @(negedge clk);
    check("rd_ack_one_cycle", 64'({ack0, ack1}), 0);

    // Write: requester changes its inputs during ISSUE
    req1 = 1; w_rn1 = 1; addr1 = 13'h1FFF; wdata1 = {8{8'hA5}};
    @(negedge clk);
    check("wr_go", 64'(mem_go), 1);
    check("wr_w_rn", 64'(mem_w_rn), 1);
    check("wr_addr", 64'(mem_addr), 64'h1FFF);
    wdata1 = '0; addr1 = '0; w_rn1 = 0;
    serve(2, 64'h1234_5678_9ABC_DEF0, gc, a0, a1, to, g, rdo);
    req1 = 0;
    check("wr_acks", 64'({a0, a1, to}), 64'b010);
    check("wr_gnt", 64'(g), 1);
    check("wr_wdata_held", mem_wdata, {8{8'hA5}});
    check("wr_addr_held", 64'(mem_addr), 64'h1FFF);
    check("wr_rdata", rdo, 64'h1234_5678_9ABC_DEF0);

    // Watchdog timeout: valid never arrives
    @(negedge clk);
    req0 = 1; addr0 = 13'h033;
    serve(0, '0, gc, a0, a1, to, g, rdo);
    req0 = 0;
    check("to_go_cycles", 64'(gc), 8);
    check("to_acks", 64'({a0, a1, to}), 64'b101);
    check("to_rdata_kept", rdo, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    check("to_clear", 64'({ack0, tout, mem_go}), 0);

    // Valid on the timeout cycle: valid wins
    req0 = 1;
    serve(8, 64'hCAFE_F00D_0000_0001, gc, a0, a1, to, g, rdo);
    req0 = 0;
    check("tv_go_cycles", 64'(gc), 8);
    check("tv_acks", 64'({a0, a1, to}), 64'b100);
    check("tv_rdata", rdo, 64'hCAFE_F00D_0000_0001);

    // Spurious valid in IDLE
    @(negedge clk);
    mem_valid = 1; mem_rdata = 64'h0BAD;
    @(negedge clk);
    mem_valid = 0;
    check("sp_acks", 64'({ack0, ack1, tout, mem_go}), 0);
    check("sp_rdata", rdata, 64'hCAFE_F00D_0000_0001);
    @(negedge clk);
    check("sp_acks_later", 64'({ack0, ack1, mem_go}), 0);

    // Reset mid-ISSUE after requester 0 was last served
    req0 = 1; addr0 = 13'h077;
    @(negedge clk);
    check("mr_go_before", 64'(mem_go), 1);
    req1 = 1;
    rst = 0;
    #1;
    check("mr_go_reset", 64'(mem_go), 0);
    @(negedge clk);
    check("mr_no_ack", 64'({ack0, ack1, mem_go}), 0);
    rst = 1;
    serve(1, 64'h55, gc, a0, a1, to, g, rdo);
    req0 = 0; req1 = 0;
    check("mr_acks", 64'({a0, a1, to}), 64'b100);
    check("mr_gnt", 64'(g), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
